lfsr_msg_buffer: RTL and testbench
==================================

Name: lfsr_msg_buffer

Overview:
- Downstream stage of the internal LFSR message generator; sits between the LFSR and the DES encryption core.
- Captures every valid LFSR word into a small FIFO and delivers the words to the DES core over a valid/ready handshake.
- Generates the LFSR `pause` request so the buffer never overflows.
- Reports the accepted word count, region completion once drained, and any overflow.

Parameters:
- N, 64: message/LFSR word width in bits.
- DEPTH, 8: FIFO depth in words; power of two, >= 4.
- ADDR_W, 3: log2(DEPTH).
- N_counter, 32: LFSR region counter width; word_count is N_counter+1 bits.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- flush  in  1  synchronous clear; driven together with the LFSR reset_counter.
- in_data  in  N  LFSR word.
- in_valid  in  1  LFSR valid; in_data is captured on any cycle this is high.
- in_done  in  1  LFSR done (region finished).
- pause  out  1  registered pause request to the LFSR.
- out_data  out  N  FIFO head word to the DES core.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  DES core accepts out_data this cycle.
- word_count  out  N_counter+1  number of words accepted since reset/flush; wraps.
- drained  out  1  region complete and FIFO empty.
- overflow_err  out  1  sticky; a word was dropped.

Behaviour:
- Reset values: FIFO empty, pause=0, out_valid=0, word_count=0, drained=0, overflow_err=0, done_seen=0. out_data is don't-care while empty.
- Storage: circular buffer with rd_ptr/wr_ptr (ADDR_W bits, wrap DEPTH-1 -> 0) and a count register (0..DEPTH).
- out_data is the combinational read of mem[rd_ptr]. out_valid = (count != 0).
- pop = out_valid && out_ready.
- push = in_valid && (count < DEPTH || pop).
  - At full with a simultaneous pop, the push is accepted and count stays DEPTH.
- Drop: in_valid && count==DEPTH && !pop drops the word and sets overflow_err. overflow_err clears only on rst or flush.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- word_count increments on every push and wraps modulo 2^(N_counter+1). Dropped words are not counted.
- pause register:
  - Each edge, pause <= (count_next >= DEPTH-2), where count_next is the post-update count.
  - The LFSR can emit one more valid word in the cycle it first sees pause, so DEPTH-2 guarantees no overflow.
  - pause deasserts the edge after count_next falls below DEPTH-2. There is no extra hysteresis.
- Completion:
  - done_seen is sticky, set on any cycle with in_done=1.
  - drained <= done_seen_next && count_next==0 (registered).
  - drained stays high until flush or rst, unless a new push arrives; a push clears it.
- Ordering: words leave in exactly the order accepted; no reordering and no duplication.
- flush:
  - Next edge: pointers, count, word_count, done_seen, drained, overflow_err and pause all go to 0.
  - flush dominates any simultaneous push or pop; that word is discarded and not counted.
- Asynchronous rst mid-operation: all outputs reach their reset values immediately, independent of clk.
- Full LFSR region with counter width k delivers 2^k + 1 words: the seed word, then one word per counter value. With no drops, word_count equals 2^k + 1 at drained.

Test Plan:
- Reset: assert rst mid-stream with count=5 -> out_valid=0, pause=0, word_count=0, overflow_err=0 without waiting for a clk edge.
- Backpressure: DEPTH=8, out_ready=0, push 6 words -> pause=1 from the cycle after the 6th push; a 7th push is accepted (count=7, overflow_err=0), and in_valid then stops.
- Overflow: fill to 8 with pause ignored, push 0xDEAD_BEEF_0000_0001 with out_ready=0 -> word dropped, overflow_err=1, word_count stays 8. Same at full with out_ready=1 -> word accepted, count stays 8.
- Ordering/handshake: push 0x0..01 through 0x0..0A while out_ready toggles 1,0,1,0 -> DES side sees 0x0..01 through 0x0..0A in order; out_data is stable while out_valid && !out_ready.
- Completion: LFSR with N_counter=4 runs a full region with random out_ready -> word_count=17, drained rises exactly one cycle after the 17th pop, overflow_err=0.
- Flush: count=5, flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, word_count=0, pause=0, drained=0.

Source files
------------

// File: rtl/lfsr_msg_buffer.sv
// Elastic buffer between the LFSR message generator and the DES core, with pause, count and completion status.
// Latency: a word accepted on an edge appears on out_data right after that edge; status outputs are registered.
// Backpressure: pause is raised once DEPTH-2 words are held; a word arriving at full with no pop is dropped and flagged.
module lfsr_msg_buffer #(
  parameter int N         = 64,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int N_counter = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [N-1:0]         in_data,
  input  logic                 in_valid,
  input  logic                 in_done,
  output logic                 pause,
  output logic [N-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_counter:0]   word_count,
  output logic                 drained,
  output logic                 overflow_err
);

  // Occupancy needs one more bit than the address to represent a full buffer.
  localparam int CNT_W = ADDR_W + 1;
  localparam int WC_W  = N_counter + 1;

  localparam logic [CNT_W-1:0]  FULL_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  PAUSE_C = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0]  ZERO_C  = '0;
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  // Storage and control state.
  logic [N-1:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WC_W-1:0]    word_count_q, word_count_d;
  logic               done_seen_q, done_seen_d;
  logic               drained_q, drained_d;
  logic               overflow_q, overflow_d;
  logic               pause_q, pause_d;

  // Handshake qualifiers for this cycle.
  logic               pop;
  logic               push;
  logic               drop;
  logic               wr_en;

  // Pointer advance with explicit wrap from the last slot back to slot 0.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    if (p == LAST_C) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + ADDR_W'(1);
    end
  endfunction

  // Head of the buffer is presented combinationally; it is meaningless while empty.
  assign out_valid = (count_q != ZERO_C);
  assign out_data  = mem_q[rd_ptr_q];

  // A push at full is still legal when the head leaves in the same cycle.
  assign pop   = out_valid && out_ready;
  assign push  = in_valid && ((count_q < FULL_C) || pop);
  assign drop  = in_valid && (count_q == FULL_C) && !pop;

  // Flush discards whatever word is offered alongside it.
  assign wr_en = push && !flush;

  // Next-state for pointers, occupancy, counters and status; flush overrides everything.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    word_count_d = word_count_q;
    done_seen_d  = done_seen_q;
    drained_d    = drained_q;
    overflow_d   = overflow_q;
    pause_d      = pause_q;

    if (flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      word_count_d = '0;
      done_seen_d  = 1'b0;
      drained_d    = 1'b0;
      overflow_d   = 1'b0;
      pause_d      = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push) begin
        wr_ptr_d     = ptr_inc(wr_ptr_q);
        word_count_d = word_count_q + WC_W'(1);
      end

      // Simultaneous push and pop leave occupancy unchanged, including at full.
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      overflow_d  = overflow_q | drop;
      done_seen_d = done_seen_q | in_done;

      // Two slots of headroom cover the one extra word the LFSR may emit
      // in the cycle it first observes pause.
      pause_d     = (count_d >= PAUSE_C);

      // Completion is reported only once the region has ended and every word
      // has left; any new word brings the count back above zero and clears it.
      drained_d   = done_seen_d && (count_d == ZERO_C);
    end
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      word_count_q <= '0;
      done_seen_q  <= 1'b0;
      drained_q    <= 1'b0;
      overflow_q   <= 1'b0;
      pause_q      <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      word_count_q <= word_count_d;
      done_seen_q  <= done_seen_d;
      drained_q    <= drained_d;
      overflow_q   <= overflow_d;
      pause_q      <= pause_d;
    end
  end

  // Word storage needs no reset: slots are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign pause        = pause_q;
  assign word_count   = word_count_q;
  assign drained      = drained_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_lfsr_msg_buffer.sv
// Bench for lfsr_msg_buffer: directed scenarios plus randomized traffic.
// A queue-based reference model predicts every output; a negedge monitor
// compares status each cycle and pops expected words on each handshake.
module tb_lfsr_msg_buffer;

  localparam int N     = 64;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int NC    = 4;
  localparam int WCMOD = 1 << (NC + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_done = 1'b0;
  logic          out_ready = 1'b0;
  logic          pause;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic [NC:0]   word_count;
  logic          drained;
  logic          overflow_err;

  lfsr_msg_buffer #(
    .N(N), .DEPTH(DEPTH), .ADDR_W(AW), .N_counter(NC)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_done(in_done),
    .pause(pause), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .word_count(word_count),
    .drained(drained), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Words in flight are a queue; status follows the rules directly.
  logic [N-1:0] exp_q[$];
  int m_cnt = 0;
  int m_wc  = 0;
  bit m_pause = 0, m_drained = 0, m_ovf = 0, m_done = 0;

  always @(posedge clk or posedge rst) begin
    bit mpop, macc, mdrop;
    if (rst) begin
      m_cnt = 0; m_wc = 0; m_pause = 0; m_drained = 0; m_ovf = 0; m_done = 0;
      exp_q.delete();
    end else begin
      mpop  = (m_cnt != 0) && out_ready;
      macc  = in_valid && (m_cnt < DEPTH || mpop);
      mdrop = in_valid && !macc;
      if (flush) begin
        m_cnt = 0; m_wc = 0; m_pause = 0; m_drained = 0; m_ovf = 0; m_done = 0;
        exp_q.delete();
      end else begin
        m_cnt = m_cnt + (macc ? 1 : 0) - (mpop ? 1 : 0);
        if (macc) exp_q.push_back(in_data);
        m_wc      = (m_wc + (macc ? 1 : 0)) % WCMOD;
        m_ovf     = m_ovf | mdrop;
        m_done    = m_done | in_done;
        m_pause   = (m_cnt >= DEPTH - 2);
        m_drained = m_done && (m_cnt == 0);
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 64'(out_valid), 64'(m_cnt != 0));
      chk("pause", 64'(pause), 64'(m_pause));
      chk("drained", 64'(drained), 64'(m_drained));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      chk("word_count", 64'(word_count), 64'(m_wc));
      if (out_valid && exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL handshake: word %h delivered, none expected at t=%0t", out_data, $time);
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; in_valid = 1'b0;
    step();
    flush = 1'b0;
  endtask

  task automatic push_n(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom}; out_ready = rdy;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    out_ready = 1'b0;
  endtask

  function automatic logic [63:0] lfsr_next(input logic [63:0] v);
    lfsr_next = {v[62:0], 1'b0} ^ (v[63] ? 64'h1B : 64'h0);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] lf;
    int idx, budget;
    bit sent;

    // Reset state
    rst = 1'b1;
    repeat (2) step();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_pause", 64'(pause), 0);
    chk("rst_word_count", 64'(word_count), 0);
    chk("rst_drained", 64'(drained), 0);
    chk("rst_overflow", 64'(overflow_err), 0);
    rst = 1'b0;
    step();

    // Backpressure: pause rises after the 6th held word, 7th still accepted
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom};
      step();
      if (i == 5) chk("bp_pause_at5", 64'(pause), 0);
    end
    chk("bp_pause_at6", 64'(pause), 1);
    in_data = {$urandom, $urandom};
    step();
    in_valid = 1'b0;
    chk("bp_overflow_at7", 64'(overflow_err), 0);
    chk("bp_word_count_at7", 64'(word_count), 7);
    drain();

    // Overflow: drop at full without pop, accept at full with pop
    do_flush();
    push_n(8, 1'b0);
    chk("ovf_word_count_full", 64'(word_count), 8);
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001; out_ready = 1'b0;
    step();
    chk("ovf_flag", 64'(overflow_err), 1);
    chk("ovf_word_count_after_drop", 64'(word_count), 8);
    in_data = {$urandom, $urandom}; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("ovf_word_count_push_pop", 64'(word_count), 9);
    chk("ovf_sticky", 64'(overflow_err), 1);
    drain();
    do_flush();
    chk("ovf_cleared_by_flush", 64'(overflow_err), 0);

    // Ordering with toggling ready
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_data = 64'(i); out_ready = (i % 2) == 1;
      step();
    end
    drain();
    chk("order_all_delivered", 64'(exp_q.size()), 0);

    // Flush dominates a simultaneous push and pop
    do_flush();
    push_n(5, 1'b0);
    chk("flush_pre_word_count", 64'(word_count), 5);
    flush = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom}; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 0);
    chk("flush_word_count", 64'(word_count), 0);
    chk("flush_pause", 64'(pause), 0);
    chk("flush_drained", 64'(drained), 0);

    // Asynchronous reset mid-stream with 5 words held and the error flag set
    push_n(9, 1'b0);
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_pause", 64'(pause), 0);
    chk("arst_word_count", 64'(word_count), 0);
    chk("arst_overflow", 64'(overflow_err), 0);
    step();
    rst = 1'b0;
    step();

    // Full LFSR region, counter width 4: seed plus 16 words, honouring pause
    lf = 64'h0123_4567_89AB_CDEF;
    idx = 0; budget = 0;
    while (idx < 17 && budget < 2000) begin
      out_ready = ($urandom % 2) == 1;
      sent = !pause;
      in_valid = sent; in_data = lf;
      step();
      if (sent) begin
        idx++;
        lf = lfsr_next(lf);
      end
      budget++;
    end
    in_valid = 1'b0; in_done = 1'b1;
    step();
    in_done = 1'b0;
    budget = 0;
    while (!drained && budget < 200) begin
      out_ready = ($urandom % 2) == 1;
      step();
      budget++;
    end
    chk("region_words_sent", 64'(idx), 17);
    chk("region_drained", 64'(drained), 1);
    chk("region_word_count", 64'(word_count), 17);
    chk("region_overflow", 64'(overflow_err), 0);
    out_ready = 1'b0;
    step();

    // Randomized traffic including drops, done pulses and flushes
    do_flush();
    repeat (1500) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom % 3) != 0;
      in_done   = ($urandom % 50) == 0;
      flush     = ($urandom % 120) == 0;
      step();
    end
    in_done = 1'b0; flush = 1'b0;
    drain();
    chk("random_all_delivered", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
